// File: rtl/pc_sequencer_pkg.sv
// Shared constants, state encoding and redirect helpers for the PC sequencer slice.
// Imported by md_busy_counter and pc_sequencer.
package pc_sequencer_pkg;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT   = 32'h0000_4180;

  localparam int MD_CNT_W            = 4;
  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } seq_state_e;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Misaligned targets are swapped for the exception vector only when checking is enabled.
  function automatic logic [31:0] redirect_target(input logic [31:0] addr,
                                                  input logic [31:0] exc,
                                                  input logic        check_en);
    return (check_en && is_misaligned(addr)) ? exc : addr;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle of the control and PC signals between the pipeline and pc_sequencer.
// The pipeline side uses master and the sequencer uses slave.
interface pc_sequencer_if;

  logic [31:0] pc_cur;
  logic        br_take;
  logic [31:0] br_target;
  logic        hazard_stall;
  logic        md_start;
  logic        md_is_div;
  logic        md_use_d;

  logic        pc_en;
  logic [31:0] pc_next;
  logic        stall;
  logic        md_busy;
  logic        pc_misalign;

  modport master (
    output pc_cur, br_take, br_target, hazard_stall, md_start, md_is_div, md_use_d,
    input  pc_en, pc_next, stall, md_busy, pc_misalign
  );

  modport slave (
    input  pc_cur, br_take, br_target, hazard_stall, md_start, md_is_div, md_use_d,
    output pc_en, pc_next, stall, md_busy, pc_misalign
  );

endinterface

// File: rtl/pc_sequencer_md_busy.sv
// Mult/div busy interval counter: loads a cycle count on a start pulse while idle,
// then counts down to zero; busy covers the start cycle and every nonzero count.
module md_busy_counter
  import pc_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_is_div,
  output logic md_busy
);

  localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
  localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);

  logic [MD_CNT_W-1:0] cnt_q, cnt_d;

  // A start that arrives while the counter is still running is dropped, never reloaded.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - MD_CNT_W'(1);
    end else if (md_start) begin
      cnt_d = md_is_div ? DIV_LOAD : MULT_LOAD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign md_busy = (cnt_q != '0) | md_start;

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC / fetch-enable controller: merges stalls, redirects and the mult/div busy interval.
// Optional feature macro: PC_SEQ_ALIGN_CHECK_EN (misaligned redirect -> EXC_VECTOR, sticky flag).
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          MULT_CYCLES  = MULT_CYCLES_DEFAULT,
  parameter int          DIV_CYCLES   = DIV_CYCLES_DEFAULT,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

`ifdef PC_SEQ_ALIGN_CHECK_EN
  localparam logic ALIGN_CHECK_EN = 1'b1;
`else
  localparam logic ALIGN_CHECK_EN = 1'b0;
`endif

  seq_state_e  state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] br_fixed;
  logic [31:0] pc_next_sel;
  logic        md_busy_raw;
  logic        stall_raw;

  assign br_fixed = redirect_target(bus.br_target, EXC_VECTOR, ALIGN_CHECK_EN);

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk       (clk),
    .reset     (reset),
    .md_start  (bus.md_start),
    .md_is_div (bus.md_is_div),
    .md_busy   (md_busy_raw)
  );

  assign stall_raw = bus.hazard_stall | (md_busy_raw & bus.md_use_d);

  // A redirect seen while frozen is parked in PEND; later redirects overwrite it.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_RUN: begin
        if (bus.br_take && stall_raw) begin
          state_d = ST_PEND;
          tgt_d   = br_fixed;
        end
      end
      ST_PEND: begin
        if (!stall_raw) begin
          state_d = ST_RUN;
        end else if (bus.br_take) begin
          tgt_d = br_fixed;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  always_comb begin
    pc_next_sel = bus.pc_cur + 32'd4;
    if (state_q == ST_PEND) begin
      pc_next_sel = tgt_q;
    end else if (bus.br_take) begin
      pc_next_sel = br_fixed;
    end
  end

  // Reset overrides the outputs combinationally so the PC sees the vector without a clock.
  assign bus.pc_next = reset ? RESET_VECTOR : pc_next_sel;
  assign bus.pc_en   = ~reset & ~stall_raw;
  assign bus.stall   = ~reset & stall_raw;
  assign bus.md_busy = ~reset & md_busy_raw;

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  always_comb begin
    misalign_d = misalign_q | (bus.br_take & is_misaligned(bus.br_target));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign bus.pc_misalign = misalign_q;
`else
  assign bus.pc_misalign = 1'b0;
`endif

endmodule
